ram_port_arbiter: RTL and testbench

- Shares the single read/write port (port A) of the dual-port data RAM between two requesters. Port 0 is the CPU. Port 1 is an auxiliary master such as a display poller or debug loader.
- After reset, performs one initialization write of an external value (for example, the switch inputs) to a fixed address, then arbitrates.
- All memory-side outputs are registered. Port 0 is a drop-in for the registered CPU-to-RAM mux in the top level.

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between two requesters after a one-shot init write.
// Memory-side outputs are registered; reads return tagged data two cycles after grant.
`default_nettype none

module ram_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int INIT_ADDR = 1022,
    parameter int MODE      = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] init_data,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] C_INIT_ADDR = ADDR_W'(INIT_ADDR);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;
    logic   w_pick1;
    logic   r_tag1_v, r_tag1_p;
    logic   r_tag2_v, r_tag2_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT) begin
            w_state_nxt = S_RUN;
        end
    end

    assign w_run = (r_state == S_RUN) && !rst;
    assign busy  = (r_state == S_INIT);

    // w_pick1: port 1 would win given the current requests; port 0 takes any leftover.
    generate
        if (MODE == 0) begin : g_fixed
            logic [WAIT_W-1:0] r_wait1;
            logic              w_force1;

            assign w_force1 = (MAX_WAIT > 0) && (r_wait1 == C_WAIT_MAX);
            assign w_pick1  = req1 && (!req0 || w_force1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wait1 <= '0;
                end else if (!req1 || gnt1) begin
                    r_wait1 <= '0;
                end else if (r_wait1 != C_WAIT_MAX) begin
                    r_wait1 <= r_wait1 + 1'b1;
                end
            end
        end else begin : g_rr
            logic r_last1;

            assign w_pick1 = req1 && (!req0 || !r_last1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_last1 <= 1'b1;
                end else if (gnt0 || gnt1) begin
                    r_last1 <= gnt1;
                end
            end
        end
    endgenerate

    assign gnt1 = w_run && w_pick1;
    assign gnt0 = w_run && req0 && !w_pick1;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (r_state == S_INIT) begin
            mem_we   <= 1'b1;
            mem_addr <= C_INIT_ADDR;
            mem_din  <= init_data;
        end else if (gnt0) begin
            mem_we   <= we0;
            mem_addr <= addr0;
            mem_din  <= wdata0;
        end else if (gnt1) begin
            mem_we   <= we1;
            mem_addr <= addr1;
            mem_din  <= wdata1;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Read tag follows the RAM's one-cycle latency behind the registered address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag1_v <= 1'b0;
            r_tag1_p <= 1'b0;
            r_tag2_v <= 1'b0;
            r_tag2_p <= 1'b0;
        end else begin
            r_tag1_v <= (gnt0 && !we0) || (gnt1 && !we1);
            r_tag1_p <= gnt1;
            r_tag2_v <= r_tag1_v;
            r_tag2_p <= r_tag1_p;
        end
    end

    assign rvalid0 = r_tag2_v && !r_tag2_p;
    assign rvalid1 = r_tag2_v && r_tag2_p;
    assign rdata   = mem_dout;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: fixed-priority and round-robin instances driven in parallel,
// checked every cycle against a behavioural arbitration and memory model.
`default_nettype none

module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int IA = 1022;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] init_data;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0]    g0, g1, rv0, rv1, bsy, mwe;
    logic [DW-1:0] rdat [2];
    logic [DW-1:0] mdin [2];
    logic [DW-1:0] mdout[2];
    logic [AW-1:0] maddr[2];

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_ADDR(IA), .MODE(0), .MAX_WAIT(MW)) u_fix (
        .clk(clk), .rst(rst), .init_data(init_data),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0[0]), .rvalid0(rv0[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1[0]), .rvalid1(rv1[0]),
        .rdata(rdat[0]), .busy(bsy[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_din(mdin[0]), .mem_dout(mdout[0])
    );

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_ADDR(IA), .MODE(1), .MAX_WAIT(MW)) u_rr (
        .clk(clk), .rst(rst), .init_data(init_data),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0[1]), .rvalid0(rv0[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1[1]), .rvalid1(rv1[1]),
        .rdata(rdat[1]), .busy(bsy[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_din(mdin[1]), .mem_dout(mdout[1])
    );

    function automatic logic [DW-1:0] seed_word(int a);
        return (a == 101) ? 32'h0000_1234 : (32'hA500_0000 | 32'(a * 7));
    endfunction

    // Dual-port RAM stand-in (port A, read-first), preloaded on its first edge.
    logic [DW-1:0] ram[2][1024];
    bit            ram_ready;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 1024; i++) ram[k][i] <= seed_word(i);
            ram_ready <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mwe[k]) ram[k][maddr[k]] <= mdin[k];
                mdout[k] <= ram[k][maddr[k]];
            end
        end
    end

    // Reference model state
    int            m_run [2];
    int            m_wait[2];
    int            m_last[2];
    logic          m_we  [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_din [2];
    logic [DW-1:0] shadow[2][1024];
    bit            ev[2][8];
    int            ep[2][8];
    logic [DW-1:0] ed[2][8];
    int            cyc;
    int            total;
    int            bad;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        int            winner, slot, nslot;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        slot  = cyc % 8;
        nslot = (cyc + 2) % 8;
        for (int k = 0; k < 2; k++) begin
            winner = -1;
            if (m_run[k] != 0 && !rst) begin
                if (req0 && req1) begin
                    if (k == 0) winner = (MW > 0 && m_wait[k] == MW) ? 1 : 0;
                    else        winner = (m_last[k] == 0) ? 1 : 0;
                end else if (req0) winner = 0;
                else if (req1)     winner = 1;
            end
            check_eq($sformatf("gnt0[m%0d]", k), g0[k], (winner == 0));
            check_eq($sformatf("gnt1[m%0d]", k), g1[k], (winner == 1));
            check_eq($sformatf("busy[m%0d]", k), bsy[k], (m_run[k] == 0));
            check_eq($sformatf("mem_we[m%0d]", k), mwe[k], m_we[k]);
            check_eq($sformatf("mem_addr[m%0d]", k), maddr[k], m_addr[k]);
            check_eq($sformatf("mem_din[m%0d]", k), mdin[k], m_din[k]);
            check_eq($sformatf("rvalid0[m%0d]", k), rv0[k], ev[k][slot] && ep[k][slot] == 0);
            check_eq($sformatf("rvalid1[m%0d]", k), rv1[k], ev[k][slot] && ep[k][slot] == 1);
            if (ev[k][slot]) check_eq($sformatf("rdata[m%0d]", k), rdat[k], ed[k][slot]);
            ev[k][slot] = 1'b0;

            if (rst) begin
                m_run[k]  = 0;
                m_wait[k] = 0;
                m_last[k] = 1;
                m_we[k]   = 1'b0;
                m_addr[k] = '0;
                m_din[k]  = '0;
                for (int s = 0; s < 8; s++) ev[k][s] = 1'b0;
            end else begin
                if (m_run[k] == 0) begin
                    m_we[k]   = 1'b1;
                    m_addr[k] = AW'(IA);
                    m_din[k]  = init_data;
                    shadow[k][IA] = init_data;
                    m_run[k]  = 1;
                end else if (winner >= 0) begin
                    wr = (winner == 1) ? we1 : we0;
                    a  = (winner == 1) ? addr1 : addr0;
                    d  = (winner == 1) ? wdata1 : wdata0;
                    m_we[k]   = wr;
                    m_addr[k] = a;
                    m_din[k]  = d;
                    if (wr) shadow[k][a] = d;
                    else begin
                        ev[k][nslot] = 1'b1;
                        ep[k][nslot] = winner;
                        ed[k][nslot] = shadow[k][a];
                    end
                    m_last[k] = winner;
                end else begin
                    m_we[k] = 1'b0;
                end
                if (!req1 || winner == 1) m_wait[k] = 0;
                else if (m_wait[k] < MW)  m_wait[k] = m_wait[k] + 1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        init_data = 32'd5;
        idle();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_wait[k] = 0; m_last[k] = 1;
            m_we[k] = 1'b0; m_addr[k] = '0; m_din[k] = '0;
            for (int i = 0; i < 1024; i++) shadow[k][i] = seed_word(i);
            for (int s = 0; s < 8; s++) begin
                ev[k][s] = 1'b0; ep[k][s] = 0; ed[k][s] = '0;
            end
        end
        repeat (2) @(negedge clk);

        // Reset, then the init write of 5 to 1022.
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // Port 0 read of preloaded address 101.
        req0 = 1'b1; addr0 = 10'd101;
        tick();
        idle();
        repeat (3) tick();

        // Both ports requesting reads continuously.
        req0 = 1'b1; addr0 = 10'd20; req1 = 1'b1; addr1 = 10'd21;
        repeat (14) tick();
        idle();
        repeat (3) tick();

        // Port 1 write immediately followed by port 0 read of the same address.
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd7; wdata1 = 32'hAA;
        tick();
        idle();
        req0 = 1'b1; addr0 = 10'd7;
        tick();
        idle();
        repeat (4) tick();

        // Reset while a read is in flight; init write must repeat.
        req0 = 1'b1; addr0 = 10'd101;
        tick();
        idle();
        rst = 1'b1; init_data = 32'hCAFE_0001;
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Randomised traffic including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            init_data = $urandom;
            req0   = ($urandom_range(0, 3) != 0);
            we0    = ($urandom_range(0, 2) == 0);
            addr0  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wdata0 = $urandom;
            req1   = ($urandom_range(0, 3) != 0);
            we1    = ($urandom_range(0, 2) == 0);
            addr1  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wdata1 = $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
